// File: rtl/rast_bus_pkg.sv
// Shared types and constants for the rasterizer memory arbiter.
package rast_bus_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int ERR_RDV = 0;
  localparam int ERR_RW  = 1;

endpackage

// File: rtl/rast_tag_fifo.sv
// Read-tag FIFO: remembers which channel issued each outstanding read so
// in-order return data can be routed back to it.
module rast_tag_fifo
  import rast_bus_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
    pop_data = tag_mem[rd_ptr_q];
    count    = count_q;
  end

  // Control state, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are meaningless until pushed, so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      tag_mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/rast_mem_arbiter.sv
// N-channel Avalon-MM master arbiter: shares one SDRAM master port between
// rasterizer stages, holds a granted request stable under waitrequest and
// routes in-order read data back through a tag FIFO.
module rast_mem_arbiter
  import rast_bus_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8,
  parameter int ARB_MODE    = ARB_RR
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]      ch_address,
  input  logic [NUM_CH-1:0]                  ch_read,
  input  logic [NUM_CH-1:0]                  ch_write,
  input  logic [NUM_CH-1:0][DATA_W/8-1:0]    ch_byteenable,
  input  logic [NUM_CH-1:0][DATA_W-1:0]      ch_writedata,
  output logic [NUM_CH-1:0]                  ch_waitrequest,
  output logic [DATA_W-1:0]                  ch_readdata,
  output logic [NUM_CH-1:0]                  ch_readdatavalid,
  output logic [ADDR_W-1:0]                  m_address,
  output logic                               m_read,
  output logic                               m_write,
  output logic [DATA_W/8-1:0]                m_byteenable,
  output logic [DATA_W-1:0]                  m_writedata,
  input  logic [DATA_W-1:0]                  m_readdata,
  input  logic                               m_readdatavalid,
  input  logic                               m_waitrequest,
  output logic [$clog2(MAX_PENDING+1)-1:0]   reads_pending,
  output logic [1:0]                         err_flags
);

  localparam int CH_W = $clog2(NUM_CH);

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [1:0]        err_q, err_d;

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] rw_both;
  logic              win_found;
  logic [CH_W-1:0]   win_idx;
  logic [CH_W-1:0]   sel;
  logic              sel_active;
  logic              rd_sel, wr_sel;
  logic              accept;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CH_W-1:0]   fifo_head;

  // A read needs a free tag slot; a channel raising both strobes counts as a read
  always_comb begin
    rw_both  = ch_read & ch_write;
    eligible = (ch_write & ~ch_read) | (ch_read & {NUM_CH{~fifo_full}});
  end

  // Winner search: rotating from last_grant+1, or from index 0 in fixed mode
  always_comb begin
    logic [CH_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == ARB_FIXED) begin
        cand = CH_W'(k);
      end else begin
        cand = CH_W'((int'(last_grant_q) + 1 + k) % NUM_CH);
      end
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant FSM next-state; LOCKED pins the master port to gnt_q until accepted or dropped
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    sel          = win_idx;
    sel_active   = win_found;
    if (state_q == LOCKED) begin
      sel        = gnt_q;
      sel_active = ch_read[gnt_q] | ch_write[gnt_q];
    end
    // Outputs must read as idle the moment reset is asserted, not at the next edge
    sel_active = sel_active & reset;
    rd_sel     = ch_read[sel];
    wr_sel     = ch_write[sel] & ~ch_read[sel];
    accept     = sel_active & ~m_waitrequest;
    case (state_q)
      IDLE: begin
        if (sel_active) begin
          if (accept) begin
            last_grant_d = win_idx;
          end else begin
            gnt_d   = win_idx;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (!sel_active) begin
          state_d = IDLE;
        end else if (accept) begin
          last_grant_d = gnt_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Master-side drive and per-channel handshake / return strobes
  always_comb begin
    m_read       = sel_active & rd_sel;
    m_write      = sel_active & wr_sel;
    m_address    = ch_address[sel];
    m_byteenable = ch_byteenable[sel];
    m_writedata  = ch_writedata[sel];
    ch_waitrequest = '1;
    if (accept) begin
      ch_waitrequest[sel] = 1'b0;
    end
    fifo_push   = accept & rd_sel;
    fifo_pop    = reset & m_readdatavalid & ~fifo_empty;
    ch_readdata = m_readdata;
    ch_readdatavalid = '0;
    if (fifo_pop) begin
      ch_readdatavalid[fifo_head] = 1'b1;
    end
  end

  // Sticky protocol error capture
  always_comb begin
    err_d = err_q;
    if (m_readdatavalid && fifo_empty) begin
      err_d[ERR_RDV] = 1'b1;
    end
    if (|rw_both) begin
      err_d[ERR_RW] = 1'b1;
    end
    err_flags = err_q;
  end

  // Arbiter state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      last_grant_q <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  rast_tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .clk       (clock),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (sel),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (reads_pending),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_rast_mem_arbiter.sv
// Scoreboard bench for rast_mem_arbiter: a round-robin instance is checked
// through accept/return queues; fixed-priority and shallow-FIFO instances
// share the same stimulus for their mode-specific checks.
module tb_rast_mem_arbiter;

  localparam int NCH = 3;
  localparam int AW  = 26;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NCH-1:0][AW-1:0]   ch_address;
  logic [NCH-1:0]           ch_read, ch_write;
  logic [NCH-1:0][DW/8-1:0] ch_be;
  logic [NCH-1:0][DW-1:0]   ch_wd;
  logic [DW-1:0]            m_readdata;
  logic                     m_rdv, m_wreq;

  logic [NCH-1:0] a_wreq, a_rdv;  logic [DW-1:0] a_rdata, a_wd;
  logic [AW-1:0]  a_addr;         logic a_rd, a_wr;
  logic [3:0]     a_be;           logic [3:0] a_pend;  logic [1:0] a_err;

  logic [NCH-1:0] f_wreq, f_rdv;  logic [DW-1:0] f_rdata, f_wd;
  logic [AW-1:0]  f_addr;         logic f_rd, f_wr;
  logic [3:0]     f_be;           logic [3:0] f_pend;  logic [1:0] f_err;

  logic [NCH-1:0] l_wreq, l_rdv;  logic [DW-1:0] l_rdata, l_wd;
  logic [AW-1:0]  l_addr;         logic l_rd, l_wr;
  logic [3:0]     l_be;           logic [1:0] l_pend;  logic [1:0] l_err;

  rast_mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(8), .ARB_MODE(0)) u_rr (
    .clock(clk), .reset(rst_n), .ch_address(ch_address), .ch_read(ch_read), .ch_write(ch_write),
    .ch_byteenable(ch_be), .ch_writedata(ch_wd), .ch_waitrequest(a_wreq), .ch_readdata(a_rdata),
    .ch_readdatavalid(a_rdv), .m_address(a_addr), .m_read(a_rd), .m_write(a_wr),
    .m_byteenable(a_be), .m_writedata(a_wd), .m_readdata(m_readdata), .m_readdatavalid(m_rdv),
    .m_waitrequest(m_wreq), .reads_pending(a_pend), .err_flags(a_err));

  rast_mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(8), .ARB_MODE(1)) u_fx (
    .clock(clk), .reset(rst_n), .ch_address(ch_address), .ch_read(ch_read), .ch_write(ch_write),
    .ch_byteenable(ch_be), .ch_writedata(ch_wd), .ch_waitrequest(f_wreq), .ch_readdata(f_rdata),
    .ch_readdatavalid(f_rdv), .m_address(f_addr), .m_read(f_rd), .m_write(f_wr),
    .m_byteenable(f_be), .m_writedata(f_wd), .m_readdata(m_readdata), .m_readdatavalid(m_rdv),
    .m_waitrequest(m_wreq), .reads_pending(f_pend), .err_flags(f_err));

  rast_mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(2), .ARB_MODE(0)) u_fl (
    .clock(clk), .reset(rst_n), .ch_address(ch_address), .ch_read(ch_read), .ch_write(ch_write),
    .ch_byteenable(ch_be), .ch_writedata(ch_wd), .ch_waitrequest(l_wreq), .ch_readdata(l_rdata),
    .ch_readdatavalid(l_rdv), .m_address(l_addr), .m_read(l_rd), .m_write(l_wr),
    .m_byteenable(l_be), .m_writedata(l_wd), .m_readdata(m_readdata), .m_readdatavalid(m_rdv),
    .m_waitrequest(m_wreq), .reads_pending(l_pend), .err_flags(l_err));

  typedef struct {
    logic [AW-1:0]  addr;
    logic           wr;
    logic [DW-1:0]  wd;
    logic [NCH-1:0] wreq;
  } acc_t;

  typedef struct {
    logic [NCH-1:0] rdv;
    logic [DW-1:0]  data;
  } ret_t;

  acc_t exp_acc[$];
  ret_t exp_ret[$];
  acc_t mon_acc;
  ret_t mon_ret;
  int   n_pass = 0;
  int   n_chk  = 0;
  bit   sb_en  = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_acc(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                          input logic [NCH-1:0] wreq);
    exp_acc.push_back('{addr, wr, wd, wreq});
  endtask

  task automatic push_ret(input logic [NCH-1:0] rdv, input logic [DW-1:0] data);
    exp_ret.push_back('{rdv, data});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ch_read  = '0;
    ch_write = '0;
    m_rdv    = 1'b0;
    m_wreq   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Monitor: compare every master-side acceptance and every read return
  always @(negedge clk) begin
    if (rst_n && sb_en) begin
      if ((a_rd || a_wr) && !m_wreq) begin
        chk("acc_expected", 64'(exp_acc.size() != 0), 64'd1);
        if (exp_acc.size() != 0) begin
          mon_acc = exp_acc.pop_front();
          chk("acc_addr", 64'(a_addr), 64'(mon_acc.addr));
          chk("acc_write", 64'(a_wr), 64'(mon_acc.wr));
          chk("acc_wreq", 64'(a_wreq), 64'(mon_acc.wreq));
          if (mon_acc.wr) chk("acc_wdata", 64'(a_wd), 64'(mon_acc.wd));
        end
      end
      if (m_rdv || (a_rdv != '0)) begin
        chk("ret_expected", 64'(exp_ret.size() != 0), 64'd1);
        if (exp_ret.size() != 0) begin
          mon_ret = exp_ret.pop_front();
          chk("ret_rdv", 64'(a_rdv), 64'(mon_ret.rdv));
          chk("ret_data", 64'(a_rdata), 64'(mon_ret.data));
        end
      end
    end
  end

  initial begin
    logic [NCH-1:0] oh;
    logic [DW-1:0]  rdat [3];
    logic [NCH-1:0] roh  [3];
    int k;

    rst_n      = 1'b1;
    idle_inputs();
    ch_address = '0;
    ch_be      = '1;
    ch_wd      = '0;
    m_readdata = '0;
    #3;

    // Reset with random channel activity
    for (int i = 0; i < NCH; i++) begin
      ch_address[i] = AW'($urandom);
      ch_wd[i]      = $urandom;
    end
    ch_read  = NCH'($urandom);
    ch_write = NCH'($urandom) | 3'b001;
    m_wreq   = 1'($urandom);
    m_rdv    = 1'($urandom);
    rst_n    = 1'b0;
    #1;
    chk("rst_wreq", 64'(a_wreq), 64'h7);
    chk("rst_mread", 64'(a_rd), 64'd0);
    chk("rst_mwrite", 64'(a_wr), 64'd0);
    chk("rst_pending", 64'(a_pend), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_rdv", 64'(a_rdv), 64'd0);
    step();
    idle_inputs();
    ch_be    = '1;
    ch_wd[0] = 32'hD000_0000;
    ch_wd[1] = 32'hD111_1111;
    ch_wd[2] = 32'hD222_2222;
    step();
    rst_n = 1'b1;

    // Round-robin fairness; a lone ch2 write first puts the pointer on ch2
    do_reset();
    ch_address[0] = 26'h10;
    ch_address[1] = 26'h20;
    ch_address[2] = 26'h30;
    ch_write = 3'b100;
    push_acc(26'h30, 1'b1, ch_wd[2], 3'b011);
    mid(); step();
    ch_write = 3'b111;
    for (int i = 0; i < 4; i++) begin
      k  = i % 3;
      oh = 3'b001 << k;
      push_acc(ch_address[k], 1'b1, ch_wd[k], ~oh);
      mid();
      chk("fixed_addr", 64'(f_addr), 64'h10);
      chk("fixed_wreq", 64'(f_wreq), 64'h6);
      step();
    end
    idle_inputs();

    // Waitrequest hold: ch1 read wins, held 4 stalled cycles, then ch0
    do_reset();
    ch_address[1] = 26'h100;
    ch_address[0] = 26'h200;
    ch_read  = 3'b010;
    ch_write = 3'b001;
    m_wreq   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("hold_addr", 64'(a_addr), 64'h100);
      chk("hold_wreq", 64'(a_wreq), 64'h7);
      step();
    end
    m_wreq = 1'b0;
    push_acc(26'h100, 1'b0, '0, 3'b101);
    mid();
    chk("hold_addr", 64'(a_addr), 64'h100);
    step();
    ch_read = '0;
    push_acc(26'h200, 1'b1, ch_wd[0], 3'b110);
    mid(); step();
    ch_write   = '0;
    m_rdv      = 1'b1;
    m_readdata = 32'h1111;
    push_ret(3'b010, 32'h1111);
    mid(); step();
    m_rdv = 1'b0;

    // Return routing: reads accepted ch2, ch0, ch1
    ch_address[2] = 26'h300;
    ch_read = 3'b100;
    push_acc(26'h300, 1'b0, '0, 3'b011);
    mid(); step();
    ch_address[0] = 26'h400;
    ch_read = 3'b001;
    push_acc(26'h400, 1'b0, '0, 3'b110);
    mid(); step();
    ch_address[1] = 26'h500;
    ch_read = 3'b010;
    push_acc(26'h500, 1'b0, '0, 3'b101);
    mid(); step();
    ch_read = '0;
    rdat[0] = 32'hAAAA; rdat[1] = 32'hBBBB; rdat[2] = 32'hCCCC;
    roh[0]  = 3'b100;   roh[1]  = 3'b001;   roh[2]  = 3'b010;
    for (int i = 0; i < 3; i++) begin
      m_rdv      = 1'b1;
      m_readdata = rdat[i];
      push_ret(roh[i], rdat[i]);
      mid();
      chk("ret_pending", 64'(a_pend), 64'(3 - i));
      step();
    end
    m_rdv = 1'b0;
    mid();
    chk("ret_pending", 64'(a_pend), 64'd0);
    step();

    // Full limit on the MAX_PENDING=2 instance
    do_reset();
    sb_en = 1'b0;
    ch_read = 3'b001;
    ch_address[0] = 26'h600;
    mid(); chk("full_rd1_wreq", 64'(l_wreq), 64'h6); step();
    ch_address[0] = 26'h604;
    mid(); chk("full_rd2_wreq", 64'(l_wreq), 64'h6); step();
    ch_address[0] = 26'h608;
    ch_address[1] = 26'h700;
    ch_write = 3'b010;
    mid();
    chk("full_wr_wreq", 64'(l_wreq), 64'h5);
    chk("full_wr_mwrite", 64'(l_wr), 64'd1);
    chk("full_wr_addr", 64'(l_addr), 64'h700);
    chk("full_pending", 64'(l_pend), 64'd2);
    step();
    ch_write = '0;
    mid();
    chk("full_held_wreq", 64'(l_wreq), 64'h7);
    chk("full_held_mread", 64'(l_rd), 64'd0);
    step();
    m_rdv      = 1'b1;
    m_readdata = 32'h5555;
    mid();
    chk("full_ret_rdv", 64'(l_rdv), 64'h1);
    chk("full_ret_wreq", 64'(l_wreq), 64'h7);
    step();
    m_rdv = 1'b0;
    mid();
    chk("full_rd3_wreq", 64'(l_wreq), 64'h6);
    chk("full_rd3_mread", 64'(l_rd), 64'd1);
    chk("full_rd3_addr", 64'(l_addr), 64'h608);
    step();
    ch_read = '0;

    // Protocol errors
    do_reset();
    sb_en = 1'b1;
    m_rdv      = 1'b1;
    m_readdata = 32'hDEAD;
    push_ret(3'b000, 32'hDEAD);
    mid(); chk("err_rdv_strobe", 64'(a_rdv), 64'd0); step();
    m_rdv = 1'b0;
    mid(); chk("err_rdv_flag", 64'(a_err), 64'h1); step();
    ch_address[0] = 26'h800;
    ch_read  = 3'b001;
    ch_write = 3'b001;
    push_acc(26'h800, 1'b0, '0, 3'b110);
    mid();
    chk("err_rw_mread", 64'(a_rd), 64'd1);
    chk("err_rw_mwrite", 64'(a_wr), 64'd0);
    step();
    ch_read  = '0;
    ch_write = '0;
    mid(); chk("err_rw_flag", 64'(a_err), 64'h3); step();

    // Reset while LOCKED, with one read still outstanding
    ch_address[2] = 26'h900;
    ch_write = 3'b100;
    m_wreq   = 1'b1;
    mid(); chk("lock_mwrite", 64'(a_wr), 64'd1); step();
    mid();
    chk("lock_addr", 64'(a_addr), 64'h900);
    chk("lock_pending", 64'(a_pend), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_wreq", 64'(a_wreq), 64'h7);
    chk("midrst_mread", 64'(a_rd), 64'd0);
    chk("midrst_mwrite", 64'(a_wr), 64'd0);
    chk("midrst_pending", 64'(a_pend), 64'd0);
    chk("midrst_err", 64'(a_err), 64'd0);
    chk("midrst_rdv", 64'(a_rdv), 64'd0);
    step();
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();

    chk("acc_queue_drained", 64'(exp_acc.size()), 64'd0);
    chk("ret_queue_drained", 64'(exp_ret.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
